cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of functional-unit result sources (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: per-source result queue depth (power of 2, >=2).
REQ-003 SHALL take PREG_W from the shared buffer package: physical-register tag width.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port recover_i  input  1  mispredict flush, synchronous.
REQ-007 SHALL have port src_valid_i  input  N_SRC  per-source result valid.
REQ-008 SHALL have port src_ready_o  output  N_SRC  per-source result accept.
REQ-009 SHALL have port src_tag_i  input  N_SRC x PREG_W  per-source destination tag.
REQ-010 SHALL have port src_data_i  input  N_SRC x 32  per-source result value.
REQ-011 SHALL have port cdb_valid_o  output  1  broadcast valid, registered.
REQ-012 SHALL have port cdb_tag_o  output  PREG_W  broadcast tag, registered.
REQ-013 SHALL have port cdb_data_o  output  32  broadcast value, registered.
REQ-014 SHALL have port cdb_src_o  output  clog2(N_SRC)  index of the winning source, registered.

Function
REQ-015 SHALL keep one FIFO of FIFO_DEPTH {tag,data} entries per source, with head/tail pointers wrapping modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-016 SHALL drive src_ready_o[i] = (count[i] != FIFO_DEPTH) && !recover_i, with no full-queue pass-through.
REQ-017 SHALL accept a result on a source when src_valid_i[i] && src_ready_o[i] at a rising edge; src_valid_i while not ready has no effect.
REQ-018 SHALL discard an accepted result with tag == 0 (not enqueued, never broadcast).
REQ-019 SHALL treat a FIFO as eligible in a cycle when its count != 0; an entry written at edge k becomes eligible in the cycle after edge k.
REQ-020 SHALL, each cycle, grant exactly one eligible FIFO chosen round-robin: the first eligible index searching upward from rr_ptr, wrapping N_SRC-1 -> 0.
REQ-021 SHALL, at the edge ending a granted cycle: pop the winner's head; load cdb_valid_o=1 with the winner's tag, data and index; set rr_ptr to (winner+1) mod N_SRC.
REQ-022 SHALL, at the edge ending a cycle with no eligible FIFO: load cdb_valid_o=0, hold cdb_tag_o/cdb_data_o/cdb_src_o, and leave rr_ptr unchanged.
REQ-023 SHALL give a minimum latency of 2 cycles: handshake in cycle c -> cdb_valid_o=1 in cycle c+2 when uncontended.
REQ-024 SHALL handle a push and a pop on the same FIFO in the same cycle (count < FIFO_DEPTH) as both taking effect, count unchanged.
REQ-025 SHALL present at most one broadcast per cycle; the CDB has no backpressure.
REQ-026 SHALL order broadcasts from a single source in acceptance order.
REQ-027 SHALL, with recover_i=1 at an edge: clear all FIFOs (count=0, pointers=0), set cdb_valid_o=0 and rr_ptr=0, and accept nothing; recover takes priority over push and pop in that cycle.
REQ-028 SHALL guarantee that, with all sources continuously backlogged, every source wins exactly once in any N_SRC consecutive grants.

Reset
REQ-029 SHALL, on rst_ni=0 (asynchronous), immediately clear all FIFO counts and pointers and set rr_ptr=0, cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0 and cdb_src_o=0.
REQ-030 SHALL hold src_ready_o=0 while rst_ni=0 and release it as all-ones (with recover_i=0) after deassertion.
REQ-031 SHALL discard in-flight queue contents when reset asserts mid-operation; no broadcast occurs after release until a new acceptance.

Verification
REQ-032 SHALL cover single result: src 2 pushes tag 5, data 0xDEAD_BEEF in cycle 3 -> cycle 5 shows cdb_valid_o=1, tag 5, data 0xDEADBEEF, src 2; cycle 6 shows cdb_valid_o=0.
REQ-033 SHALL cover contention: all 4 sources push one result in the same cycle with rr_ptr=0 -> broadcasts on 4 consecutive cycles in src order 0,1,2,3; rr_ptr ends at 0.
REQ-034 SHALL cover full FIFO: src 1 pushes 3 results while src 0 is continuously backlogged ahead of it -> src_ready_o[1]=0 after 2 are queued; after drain, 3 broadcasts in push order.
REQ-035 SHALL cover tag zero: src 0 pushes tag 0, then tag 7 -> only tag 7 is broadcast; src_ready_o[0] stays 1 throughout.
REQ-036 SHALL cover recover: 3 results are queued and recover_i pulses 1 cycle -> no broadcast afterwards, src_ready_o=0 during the pulse, rr_ptr=0.
REQ-037 SHALL cover async reset mid-burst: rst_ni drops between edges -> cdb_valid_o=0 immediately (before the next edge), and all queues are empty after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a round-robin arbitrated,
// registered common data bus broadcast.
package buf_pkg;
  localparam int PREG_W = 6;
endpackage

module cdb_arbiter import buf_pkg::*; #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            recover_i,
  input  logic [N_SRC-1:0]                src_valid_i,
  output logic [N_SRC-1:0]                src_ready_o,
  input  logic [N_SRC-1:0][PREG_W-1:0]    src_tag_i,
  input  logic [N_SRC-1:0][31:0]          src_data_i,
  output logic                            cdb_valid_o,
  output logic [PREG_W-1:0]               cdb_tag_o,
  output logic [31:0]                     cdb_data_o,
  output logic [$clog2(N_SRC)-1:0]        cdb_src_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(N_SRC);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [PREG_W-1:0] tag_mem [N_SRC][FIFO_DEPTH];
  logic [31:0] data_mem [N_SRC][FIFO_DEPTH];
  logic [AW-1:0] head_q [N_SRC], head_d [N_SRC], tail_q [N_SRC], tail_d [N_SRC];
  logic [AW:0] cnt_q [N_SRC], cnt_d [N_SRC];
  logic [N_SRC-1:0] push, pop;
  logic [SW-1:0] rr_q, rr_d, win, cdb_src_q, cdb_src_d;
  logic any;
  int idx;
  logic cdb_valid_q, cdb_valid_d;
  logic [PREG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0] cdb_data_q, cdb_data_d;
  // Scan downward so the last hit is the first eligible index upward from rr_q.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (cnt_q[idx] != '0) begin
        any = 1'b1;
        win = SW'(idx);
      end
    end
  end
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ready_o[i] = rst_ni && !recover_i && cnt_q[i] != FULL;
      push[i] = src_valid_i[i] && rst_ni && !recover_i && cnt_q[i] != FULL && src_tag_i[i] != '0;
      pop[i] = any && win == SW'(i);
      head_d[i] = recover_i ? '0 : head_q[i] + AW'(pop[i]);
      tail_d[i] = recover_i ? '0 : tail_q[i] + AW'(push[i]);
      cnt_d[i] = recover_i ? '0 : cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end
  always_comb begin
    cdb_valid_d = any && !recover_i;
    cdb_tag_d = cdb_valid_d ? tag_mem[win][head_q[win]] : cdb_tag_q;
    cdb_data_d = cdb_valid_d ? data_mem[win][head_q[win]] : cdb_data_q;
    cdb_src_d = cdb_valid_d ? win : cdb_src_q;
    rr_d = recover_i ? '0 : !any ? rr_q : win == SW'(N_SRC - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        tag_mem[i][tail_q[i]] <= src_tag_i[i];
        data_mem[i][tail_q[i]] <= src_data_i[i];
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q <= '0;
      cdb_data_q <= '0;
      cdb_src_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q <= cdb_src_d;
      for (int i = 0; i < N_SRC; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o = cdb_tag_q;
  assign cdb_data_o = cdb_data_q;
  assign cdb_src_o = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed broadcasts for cdb_arbiter.
module tb_cdb_arbiter;
  import buf_pkg::*;
  logic clk_i = 1'b0;
  logic rst_ni, recover_i;
  logic [3:0] src_valid_i, src_ready_o;
  logic [3:0][PREG_W-1:0] src_tag_i;
  logic [3:0][31:0] src_data_i;
  logic cdb_valid_o;
  logic [PREG_W-1:0] cdb_tag_o;
  logic [31:0] cdb_data_o;
  logic [1:0] cdb_src_o;
  int checks = 0;
  int failures = 0;
  cdb_arbiter #(.N_SRC(4), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .recover_i(recover_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_tag_i(src_tag_i), .src_data_i(src_data_i),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o),
    .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic cdb(input string name, input logic [5:0] t, input logic [31:0] d, input logic [1:0] s);
    chk({name, "_v"}, 64'(cdb_valid_o), 64'd1);
    chk({name, "_tag"}, 64'(cdb_tag_o), 64'(t));
    chk({name, "_data"}, 64'(cdb_data_o), 64'(d));
    chk({name, "_src"}, 64'(cdb_src_o), 64'(s));
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input int s, input logic [5:0] t, input logic [31:0] d);
    src_valid_i[s] = 1'b1;
    src_tag_i[s] = t;
    src_data_i[s] = d;
  endtask
  task automatic clr();
    src_valid_i = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_ni = 1'b0;
    recover_i = 1'b0;
    src_valid_i = '0;
    src_tag_i = '0;
    src_data_i = '0;
    #1;
    chk("rst_valid", 64'(cdb_valid_o), 64'd0);
    chk("rst_tag", 64'(cdb_tag_o), 64'd0);
    chk("rst_data", 64'(cdb_data_o), 64'd0);
    chk("rst_src", 64'(cdb_src_o), 64'd0);
    chk("rst_ready", 64'(src_ready_o), 64'h0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    chk("rel_ready", 64'(src_ready_o), 64'hf);
    push(2, 6'd5, 32'hDEAD_BEEF);
    tick();
    clr();
    chk("single_lat1", 64'(cdb_valid_o), 64'd0);
    tick();
    cdb("single", 6'd5, 32'hDEAD_BEEF, 2'd2);
    tick();
    chk("single_after", 64'(cdb_valid_o), 64'd0);
    chk("single_hold", 64'(cdb_tag_o), 64'd5);
    recover_i = 1'b1;
    tick();
    recover_i = 1'b0;
    for (int s = 0; s < 4; s++) push(s, 6'(8 + s), 32'hA0 + s);
    tick();
    clr();
    chk("cont_lat1", 64'(cdb_valid_o), 64'd0);
    for (int s = 0; s < 4; s++) begin
      tick();
      cdb($sformatf("cont%0d", s), 6'(8 + s), 32'hA0 + s, 2'(s));
    end
    tick();
    chk("cont_idle", 64'(cdb_valid_o), 64'd0);
    push(3, 6'd13, 32'h33);
    push(0, 6'd14, 32'h44);
    tick();
    clr();
    tick();
    cdb("rr0_first", 6'd14, 32'h44, 2'd0);
    tick();
    cdb("rr0_second", 6'd13, 32'h33, 2'd3);
    tick();
    chk("rr0_idle", 64'(cdb_valid_o), 64'd0);
    push(0, 6'd0, 32'h999);
    #1 chk("tz_ready_a", 64'(src_ready_o[0]), 64'd1);
    tick();
    chk("tz_ready_b", 64'(src_ready_o[0]), 64'd1);
    push(0, 6'd7, 32'h777);
    tick();
    clr();
    chk("tz_none", 64'(cdb_valid_o), 64'd0);
    chk("tz_ready_c", 64'(src_ready_o[0]), 64'd1);
    tick();
    cdb("tz7", 6'd7, 32'h777, 2'd0);
    tick();
    chk("tz_idle", 64'(cdb_valid_o), 64'd0);
    recover_i = 1'b1;
    tick();
    recover_i = 1'b0;
    push(0, 6'd10, 32'h110);
    push(1, 6'd21, 32'h121);
    tick();
    push(0, 6'd11, 32'h111);
    push(1, 6'd22, 32'h122);
    chk("full_lat", 64'(cdb_valid_o), 64'd0);
    tick();
    clr();
    push(0, 6'd12, 32'h112);
    push(1, 6'd30, 32'h130);
    #1 chk("full_ready1", 64'(src_ready_o[1]), 64'd0);
    chk("full_ready0", 64'(src_ready_o[0]), 64'd1);
    cdb("full_b0", 6'd10, 32'h110, 2'd0);
    tick();
    clr();
    push(1, 6'd23, 32'h123);
    cdb("full_b1", 6'd21, 32'h121, 2'd1);
    tick();
    clr();
    cdb("full_b2", 6'd11, 32'h111, 2'd0);
    tick();
    cdb("full_b3", 6'd22, 32'h122, 2'd1);
    tick();
    cdb("full_b4", 6'd12, 32'h112, 2'd0);
    tick();
    cdb("full_b5", 6'd23, 32'h123, 2'd1);
    tick();
    chk("full_idle", 64'(cdb_valid_o), 64'd0);
    for (int s = 0; s < 3; s++) push(s, 6'(1 + s), 32'h50 + s);
    tick();
    clr();
    recover_i = 1'b1;
    #1 chk("rec_ready", 64'(src_ready_o), 64'h0);
    tick();
    recover_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rec_idle%0d", c), 64'(cdb_valid_o), 64'd0);
      tick();
    end
    push(3, 6'd17, 32'h317);
    push(0, 6'd18, 32'h318);
    tick();
    clr();
    tick();
    cdb("rec_rr0", 6'd18, 32'h318, 2'd0);
    tick();
    cdb("rec_rr1", 6'd17, 32'h317, 2'd3);
    for (int s = 0; s < 4; s++) push(s, 6'(40 + s), 32'h400 + s);
    tick();
    clr();
    tick();
    cdb("ar_pre", 6'd40, 32'h400, 2'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_valid", 64'(cdb_valid_o), 64'd0);
    chk("ar_tag", 64'(cdb_tag_o), 64'd0);
    chk("ar_ready", 64'(src_ready_o), 64'h0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    chk("ar_rel_ready", 64'(src_ready_o), 64'hf);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ar_idle%0d", c), 64'(cdb_valid_o), 64'd0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
